// File: rtl/lbm_macroscopic.sv
// D2Q9 macroscopic moments: rho, ux, uy for one lattice cell.
// Iterative restoring divider, one cell in flight, valid/ready both sides.
module lbm_macroscopic #(
  parameter int GRID_DIM        = 256,
  parameter int DATA_WIDTH      = 64,
  parameter int FRACTIONAL_BITS = 56,
  parameter int ADDRESS_WIDTH   = $clog2(GRID_DIM),
  parameter int DATA_WIDTH_F    = 9*DATA_WIDTH
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH_F-1:0]  fin,
  input  logic [ADDRESS_WIDTH-1:0] in_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    rho,
  output logic [DATA_WIDTH-1:0]    ux,
  output logic [DATA_WIDTH-1:0]    uy,
  output logic [ADDRESS_WIDTH-1:0] out_addr,
  output logic                     div_zero,
  output logic                     sat,
  output logic                     frame_done
);

  localparam int DW = DATA_WIDTH;
  localparam int FB = FRACTIONAL_BITS;
  localparam int QW = DW + FB;
  localparam int CW = $clog2(QW);
  localparam logic [DW-1:0] MAXP = {1'b0, {(DW-1){1'b1}}};
  localparam logic [ADDRESS_WIDTH-1:0] LAST =
    ADDRESS_WIDTH'(GRID_DIM-1);

  typedef enum logic [2:0] {
    S_IDLE, S_SUM, S_LOAD, S_DIV_X, S_DIV_Y, S_OUT
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH_F-1:0]  fin_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DW-1:0] f [9];
  logic [DW-1:0] rho_c, jx_c, jy_c;
  logic [DW-1:0] rho_s, jx_s, jy_s;
  logic [DW-1:0] dvs, rem, rem_nx, ux_t;
  logic [QW-1:0] quo, quo_nx;
  logic [DW:0]   rem_sh, diff;
  logic [CW-1:0] cnt;
  logic          ge, big, neg, last, rho_le0, sat_x;
  logic [DW-1:0] mag_q, res;

  function automatic logic [DW-1:0] mag(input logic [DW-1:0] v);
    return v[DW-1] ? -v : v;
  endfunction

  always_comb begin
    for (int k = 0; k < 9; k++) f[k] = fin_q[k*DW +: DW];
  end

  always_comb begin
    rho_c = '0;
    for (int k = 0; k < 9; k++) rho_c = rho_c + f[k];
    jx_c = f[1] + f[5] + f[8] - f[3] - f[6] - f[7];
    jy_c = f[2] + f[5] + f[6] - f[4] - f[7] - f[8];
  end

  assign rho_le0 = rho_s[DW-1] | ~|rho_s;
  assign last    = cnt == CW'(QW-1);
  assign neg     = (state == S_DIV_X) ? jx_s[DW-1] : jy_s[DW-1];

  // one restoring step; the final step also yields the signed result
  always_comb begin
    rem_sh = {rem, quo[QW-1]};
    diff   = rem_sh - {1'b0, dvs};
    ge     = ~diff[DW];
    rem_nx = ge ? diff[DW-1:0] : rem_sh[DW-1:0];
    quo_nx = {quo[QW-2:0], ge};
    big    = |quo_nx[QW-1:DW-1];
    mag_q  = big ? MAXP : quo_nx[DW-1:0];
    res    = neg ? -mag_q : mag_q;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (in_valid) state_n = S_SUM;
      S_SUM:   state_n = S_LOAD;
      S_LOAD:  state_n = rho_le0 ? S_OUT : S_DIV_X;
      S_DIV_X: if (last) state_n = S_DIV_Y;
      S_DIV_Y: if (last) state_n = S_OUT;
      S_OUT:   if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign in_ready  = state == S_IDLE;
  assign out_valid = state == S_OUT;

  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      fin_q      <= '0;
      addr_q     <= '0;
      rho_s      <= '0;
      jx_s       <= '0;
      jy_s       <= '0;
      dvs        <= '0;
      rem        <= '0;
      quo        <= '0;
      cnt        <= '0;
      ux_t       <= '0;
      sat_x      <= 1'b0;
      rho        <= '0;
      ux         <= '0;
      uy         <= '0;
      out_addr   <= '0;
      div_zero   <= 1'b0;
      sat        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            fin_q  <= fin;
            addr_q <= in_addr;
          end
        end
        S_SUM: begin
          rho_s <= rho_c;
          jx_s  <= jx_c;
          jy_s  <= jy_c;
        end
        S_LOAD: begin
          dvs   <= rho_s;
          rem   <= '0;
          quo   <= {mag(jx_s), FB'(0)};
          cnt   <= '0;
          sat_x <= 1'b0;
          if (rho_le0) begin
            rho      <= rho_s;
            ux       <= '0;
            uy       <= '0;
            div_zero <= 1'b1;
            sat      <= 1'b0;
            out_addr <= addr_q;
          end
        end
        S_DIV_X: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (last) begin
            ux_t  <= res;
            sat_x <= big;
            rem   <= '0;
            quo   <= {mag(jy_s), FB'(0)};
            cnt   <= '0;
          end
        end
        S_DIV_Y: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (last) begin
            rho      <= rho_s;
            ux       <= ux_t;
            uy       <= res;
            sat      <= sat_x | big;
            div_zero <= 1'b0;
            out_addr <= addr_q;
          end
        end
        S_OUT: begin
          if (out_ready && out_addr == LAST) frame_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lbm_macroscopic.sv
// Testbench for lbm_macroscopic: directed and random cells against
// a plain-arithmetic moment/division model.
module tb_lbm_macroscopic;

  localparam int DW = 64;
  localparam int FW = 9*DW;
  localparam int AW = 8;

  logic          CLOCK_50 = 1'b0;
  logic          RESET;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] fin;
  logic [AW-1:0] in_addr;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] rho, ux, uy;
  logic [AW-1:0] out_addr;
  logic          div_zero, sat, frame_done;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;

  lbm_macroscopic dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fin       (fin),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rho       (rho),
    .ux        (ux),
    .uy        (uy),
    .out_addr  (out_addr),
    .div_zero  (div_zero),
    .sat       (sat),
    .frame_done(frame_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) if (frame_done) fd_cnt++;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] qdiv(input longint j, input longint d,
                                       output logic s);
    logic [127:0] num, q;
    logic [63:0]  m;
    m   = (j < 0) ? 64'(-j) : 64'(j);
    num = {64'd0, m} << 56;
    q   = num / {64'd0, 64'(d)};
    s   = q > 128'h7FFF_FFFF_FFFF_FFFF;
    if (s) q = 128'h7FFF_FFFF_FFFF_FFFF;
    return (j < 0) ? -q[63:0] : q[63:0];
  endfunction

  function automatic void model(input logic [FW-1:0] f,
                                output logic [63:0] r, x, y,
                                output logic dz, st);
    longint fk[9];
    longint rs, jx, jy;
    logic   sx, sy;
    for (int k = 0; k < 9; k++) fk[k] = longint'(f[k*DW +: DW]);
    rs = 0;
    for (int k = 0; k < 9; k++) rs += fk[k];
    jx = fk[1] + fk[5] + fk[8] - fk[3] - fk[6] - fk[7];
    jy = fk[2] + fk[5] + fk[6] - fk[4] - fk[7] - fk[8];
    r  = rs;
    dz = rs <= 0;
    x = '0; y = '0; st = 1'b0;
    if (!dz) begin
      x  = qdiv(jx, rs, sx);
      y  = qdiv(jy, rs, sy);
      st = sx | sy;
    end
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 2000) begin
      @(posedge CLOCK_50); #1; k++;
    end
    chk("in_ready_wait", in_ready, 1'b1);
  endtask

  task automatic run_cell(input logic [FW-1:0] f, input logic [AW-1:0] a,
                          input int hold);
    logic [63:0] er, ex, ey;
    logic        edz, est;
    logic [255:0] snap;
    int lat;
    model(f, er, ex, ey, edz, est);
    wait_ready();
    @(negedge CLOCK_50);
    fin = f; in_addr = a; in_valid = 1'b1;
    @(posedge CLOCK_50); #1;
    in_valid = 1'b0;
    fin = {$urandom, $urandom, $urandom, $urandom};
    chk("busy_in_ready", in_ready, 1'b0);
    lat = 0;
    while (lat < 1000) begin
      @(posedge CLOCK_50); #1; lat++;
      if (out_valid) break;
    end
    chk("latency", lat, edz ? 2 : 242);
    if (out_valid) begin
      chk("rho", rho, er);
      chk("ux", ux, ex);
      chk("uy", uy, ey);
      chk("div_zero", div_zero, edz);
      chk("sat", sat, est);
      chk("out_addr", out_addr, a);
      snap = {rho, ux, uy, out_addr, div_zero, sat, 54'd0};
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        fin = {$urandom, $urandom, $urandom};
        @(posedge CLOCK_50); #1;
        chk("hold_outputs", {rho, ux, uy, out_addr, div_zero, sat, 54'd0},
            snap);
        chk("hold_ready", {out_valid, in_ready}, 2'b10);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge CLOCK_50); #1;
      out_ready = 1'b0;
      chk("post_hs_ready", {out_valid, in_ready}, 2'b01);
      chk("frame_done", frame_done, a == 8'd255);
    end
  endtask

  function automatic logic [FW-1:0] rnd_phys();
    logic [FW-1:0] f;
    for (int k = 0; k < 9; k++)
      f[k*DW +: DW] = {8'd0, $urandom, 24'($urandom)};
    return f;
  endfunction

  function automatic logic [FW-1:0] rnd_full();
    logic [FW-1:0] f;
    for (int k = 0; k < 9; k++) f[k*DW +: DW] = {$urandom, $urandom};
    return f;
  endfunction

  initial begin
    logic [FW-1:0] f;
    int seen;
    RESET = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    fin = '0; in_addr = '0;
    #2 RESET = 1'b0;
    #1;
    chk("rst_ready_valid", {in_ready, out_valid}, 2'b10);
    chk("rst_data", {rho, ux, uy, out_addr}, '0);
    chk("rst_flags", {div_zero, sat, frame_done}, 3'b000);
    repeat (3) @(negedge CLOCK_50);
    RESET = 1'b1;

    f = '0; f[0*DW +: DW] = 64'h0100_0000_0000_0000;
    run_cell(f, 8'd1, 0);
    f = '0;
    f[0*DW +: DW] = 64'h0080_0000_0000_0000;
    f[1*DW +: DW] = 64'h0080_0000_0000_0000;
    run_cell(f, 8'd2, 10);
    chk("ux_half", ux, 64'h0080_0000_0000_0000);
    f = '0;
    f[2*DW +: DW] = 64'h0040_0000_0000_0000;
    f[7*DW +: DW] = 64'h00C0_0000_0000_0000;
    run_cell(f, 8'd3, 0);
    chk("ux_m075", ux, 64'hFF40_0000_0000_0000);
    chk("uy_m050", uy, 64'hFF80_0000_0000_0000);
    run_cell('0, 8'd4, 3);
    f = '0;
    f[1*DW +: DW] = 64'h0400_0000_0000_0000;
    f[3*DW +: DW] = 64'hFC08_0000_0000_0000;
    run_cell(f, 8'd5, 0);
    chk("sat_ux", {ux, sat}, {64'h7FFF_FFFF_FFFF_FFFF, 1'b1});
    for (int i = 0; i < 6; i++) run_cell(rnd_phys(), 8'(10 + i), i % 2);

    // abort a cell mid-divide
    wait_ready();
    @(negedge CLOCK_50);
    fin = rnd_phys(); in_addr = 8'd77; in_valid = 1'b1;
    @(posedge CLOCK_50); #1; in_valid = 1'b0;
    repeat (20) @(posedge CLOCK_50);
    #3 RESET = 1'b0;
    #1;
    chk("abort_ready_valid", {in_ready, out_valid}, 2'b10);
    chk("abort_data", {rho, ux, uy, out_addr}, '0);
    @(negedge CLOCK_50); RESET = 1'b1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge CLOCK_50); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);

    fd_cnt = 0;
    for (int a = 0; a < 256; a++) run_cell(rnd_full(), 8'(a), 0);
    @(posedge CLOCK_50); #1;
    chk("frame_done_count", fd_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
